// File: rtl/psum_collect_pkg.sv
// ============================================================================
// Module  : psum_collect_pkg
// Brief   : Shared types and constants for the partial-sum column collector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package psum_collect_pkg;

    localparam int c_OC_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } collect_state_t;

    // Buffered entry at the default partial-sum width.
    typedef struct packed {
        logic                     last;
        logic [c_OC_W_DEFAULT-1:0] data;
    } psum_entry_t;

endpackage

`default_nettype wire

// File: rtl/psum_collect_fifo.sv
// ============================================================================
// Module  : psum_collect_fifo
// Brief   : Small synchronous FIFO with registered occupancy and full/empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_collect_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage needs no reset: the head is only consumed while count != 0.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/psum_column_collector.sv
// ============================================================================
// Module  : psum_column_collector
// Brief   : Drains one PE column over the scan chain into a valid/ready stream.
//           Optional ReLU on capture: define PSUM_COLLECT_RELU_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_column_collector
    import psum_collect_pkg::*;
#(
    parameter int OC_W       = c_OC_W_DEFAULT,
    parameter int N_ROWS     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    output logic            o_cscan_en,
    input  logic [OC_W-1:0] i_sc_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [OC_W-1:0] o_data,
    output logic            o_last,
    output logic            o_busy,
    output logic            o_done
);

    localparam int c_CNT_W = $clog2(N_ROWS + 1);

    typedef struct packed {
        logic            last;
        logic [OC_W-1:0] data;
    } entry_t;

    collect_state_t     r_state;
    collect_state_t     w_state_next;
    logic [c_CNT_W-1:0] r_shift_cnt;
    logic               w_cscan_en;
    logic               w_last_push;
    logic [OC_W-1:0]    w_sc_val;
    entry_t             w_push_entry;
    entry_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;

`ifdef PSUM_COLLECT_RELU_EN
    // Any sign-set pattern (negatives, -0.0, negative NaN) clamps to +0.0.
    assign w_sc_val = i_sc_data[OC_W-1] ? '0 : i_sc_data;
`else
    assign w_sc_val = i_sc_data;
`endif

    assign w_last_push  = (r_shift_cnt == c_CNT_W'(N_ROWS - 1));
    assign w_push_entry = '{last: w_last_push, data: w_sc_val};
    assign w_pop        = o_valid && i_ready;

    psum_collect_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OC_W + 1)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (w_cscan_en),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start)                   w_state_next = SHIFT;
            SHIFT:   if (w_cscan_en && w_last_push) w_state_next = FLUSH;
            FLUSH:   if (w_pop && w_head.last)      w_state_next = IDLE;
            default:                                w_state_next = IDLE;
        endcase
    end

    // Shift enable depends only on registered state, never on i_ready.
    always_comb begin
        w_cscan_en = (r_state == SHIFT) && !w_full;
        o_busy     = (r_state != IDLE);
        o_cscan_en = w_cscan_en;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_shift_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_shift_cnt <= '0;
        end else if (w_cscan_en) begin
            r_shift_cnt <= r_shift_cnt + c_CNT_W'(1);
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = o_valid ? w_head.data : '0;
    assign o_last  = o_valid && w_head.last;
    assign o_done  = w_pop && w_head.last;

endmodule

`default_nettype wire

// File: tb/tb_psum_column_collector.sv
// ============================================================================
// Module  : tb_psum_column_collector
// Brief   : Randomised bench with a scan-chain stimulus model and a
//           count-based reference of the drain stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_column_collector;

    localparam int OC_W  = 16;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            cscan_en;
    logic [OC_W-1:0] sc_data;
    logic            valid;
    logic            ready;
    logic [OC_W-1:0] data;
    logic            last;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    psum_column_collector #(
        .OC_W       (OC_W),
        .N_ROWS     (N),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (start),
        .o_cscan_en (cscan_en),
        .i_sc_data  (sc_data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_data     (data),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [OC_W-1:0] chain   [N];
    logic [OC_W-1:0] vals    [N];
    logic [OC_W-1:0] exp_seq [N];

    bit en_prev, m_active, start_req;
    bit pend_push, pend_pop, pend_done, pend_start;
    int m_pushed, m_popped;
    int ready_mode, stall_left, cyc;
    int beats, lasts, dones, first_valid, done_cyc, stall_pushes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [OC_W-1:0] ref_relu(input logic [OC_W-1:0] v);
`ifdef PSUM_COLLECT_RELU_EN
        return v[OC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // One clock cycle: advance chain and model, drive inputs, compare outputs.
    task automatic tick();
        bit exp_en, exp_valid, exp_done;
        @(negedge clk);
        if (en_prev) begin
            for (int i = N - 1; i > 0; i--) chain[i] = chain[i-1];
            chain[0] = OC_W'($urandom);
        end
        if (pend_push) m_pushed++;
        if (pend_pop)  m_popped++;
        if (pend_done) m_active = 1'b0;
        if (pend_start) begin
            m_active = 1'b1;
            m_pushed = 0;
            m_popped = 0;
        end
        sc_data   = chain[N-1];
        start     = start_req;
        start_req = 1'b0;
        case (ready_mode)
            1:       ready = ($urandom_range(0, 1) == 1);
            2:       if (stall_left > 0) begin ready = 1'b0; stall_left--; end
                     else ready = 1'b1;
            default: ready = 1'b1;
        endcase
        #1;
        exp_en    = m_active && (m_pushed < N) && ((m_pushed - m_popped) < DEPTH);
        exp_valid = (m_pushed > m_popped);
        exp_done  = exp_valid && ready && (m_popped == N - 1);
        check("busy", busy, m_active);
        check("cscan_en", cscan_en, exp_en);
        check("valid", valid, exp_valid);
        if (exp_valid && m_popped < N) begin
            check("data", data, exp_seq[m_popped]);
            check("last", last, (m_popped == N - 1));
        end
        check("done", done, exp_done);
        pend_push  = exp_en;
        pend_pop   = exp_valid && ready;
        pend_done  = exp_done;
        pend_start = start && !m_active;
        if (ready_mode == 2 && !ready && cscan_en) stall_pushes++;
        if (valid && ready) begin
            beats++;
            if (last) lasts++;
        end
        if (done) begin dones++; done_cyc = cyc; end
        if (valid && first_valid < 0) first_valid = cyc;
        en_prev = cscan_en;
    endtask

    task automatic apply_reset_mid();
        #1 rstn = 1'b0;
        #1;
        check("rst_cscan_en", cscan_en, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        {en_prev, m_active, pend_push, pend_pop, pend_done, pend_start} = '0;
        m_pushed = 0;
        m_popped = 0;
        #1;
        check("post_rst_valid", valid, 0);
        check("post_rst_busy", busy, 0);
    endtask

    task automatic run_drain(input int mode, input int stall, input int restart_at, input int abort_at);
        for (int i = 0; i < N; i++) chain[i] = vals[i];
        for (int k = 0; k < N; k++) exp_seq[k] = ref_relu(vals[N-1-k]);
        beats = 0; lasts = 0; dones = 0; first_valid = -1; done_cyc = -1; stall_pushes = 0;
        ready_mode = mode;
        stall_left = stall;
        start_req  = 1'b1;
        cyc = 0;
        tick();
        do begin
            cyc++;
            if (cyc == restart_at) start_req = 1'b1;
            tick();
            if (cyc == abort_at) begin
                apply_reset_mid();
                return;
            end
        end while (m_active && cyc < 300);
        check("timeout", m_active, 0);
        check("beats", beats, N);
        check("last_count", lasts, 1);
        check("done_count", dones, 1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < N; i++) vals[i] = OC_W'(16'h3C00 + i * 16'h0160);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; ready = 1'b0; sc_data = '0;
        {en_prev, m_active, start_req, pend_push, pend_pop, pend_done, pend_start} = '0;
        m_pushed = 0; m_popped = 0; ready_mode = 0; stall_left = 0; cyc = 0;
        for (int i = 0; i < N; i++) chain[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_cscan_en", cscan_en, 0);
        check("reset_valid", valid, 0);
        check("reset_data", data, 0);
        check("reset_last", last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rstn = 1'b1;

        load_basic();
        run_drain(0, 0, -1, -1);
        check("basic_first_valid", first_valid, 2);
        check("basic_done_cyc", done_cyc, N + 1);
        check("basic_idle_cyc", cyc, N + 2);

        load_basic();
        run_drain(2, 11, -1, -1);
        check("bp_pushes", stall_pushes, DEPTH);

        load_basic();
        run_drain(0, 0, 3, -1);

        load_basic();
        run_drain(0, 0, -1, 5);
        load_basic();
        run_drain(0, 0, -1, -1);
        check("rerun_first_valid", first_valid, 2);
        check("rerun_done_cyc", done_cyc, N + 1);

        vals[0] = 16'hC000; vals[1] = 16'h8000; vals[2] = 16'h4000; vals[3] = 16'h3C00;
        vals[4] = 16'hFC00; vals[5] = 16'h7E00; vals[6] = 16'hFE00; vals[7] = 16'h0001;
        run_drain(0, 0, -1, -1);

        for (int d = 0; d < 100; d++) begin
            for (int i = 0; i < N; i++) vals[i] = OC_W'($urandom);
            run_drain(1, 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
